// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the default NOP instruction, the selPC meaning constants and a helper that
// forms a taken branch/jump target from the ALU result.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  // Fetch FSM states, 2-bit registered encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // addi x0,x0,0 -- presented whenever no real instruction is held
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // selPC meanings driven by the control logic
  localparam logic PC_TAKEN    = 1'b1;
  localparam logic PC_NOTTAKEN = 1'b0;

  // Taken target: ALU result with bit 0 forced low (JALR-style clearing)
  function automatic logic [31:0] taken_target(input logic [31:0] alu);
    return {alu[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage. Requests one word from instruction memory, holds it
// until downstream commits, then advances pc sequentially or to a taken
// target. A taken target with bit 1 set halts the stage with a sticky
// misalign flag until reset.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   selPC       1 = branch/jump taken, 0 = sequential (sampled on commit)
//   alu_result  branch/jump target (sampled on commit)
//   commit      downstream finished the held instruction
//   imem_req    instruction-memory read request
//   imem_addr   instruction-memory word address (= pc)
//   imem_ack    read data valid this cycle
//   imem_rdata  instruction word, valid with imem_ack
//   pc          address of the held instruction
//   pc_four     pc + 4 (mod 2^32)
//   inst        held instruction, or NOP_INST when inst_valid = 0
//   inst_valid  inst is a real fetched instruction
//   misalign    sticky: a taken target was not word-aligned
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        selPC,
  input  logic [31:0] alu_result,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        misalign
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_inst;
  logic [31:0]  w_inst_nxt;
  logic         r_misalign;
  logic         w_misalign_nxt;
  logic [31:0]  w_target;

  // Registered copies of the outputs, computed from next-state values so
  // every output changes only on a clock edge.
  logic         r_imem_req;
  logic         r_inst_valid;
  logic [31:0]  r_inst_out;
  logic [31:0]  r_pc_four;
  logic         w_imem_req_nxt;
  logic         w_inst_valid_nxt;
  logic [31:0]  w_inst_out_nxt;
  logic [31:0]  w_pc_four_nxt;

  // Next-state, next-pc and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_nxt     = r_inst;
    w_misalign_nxt = r_misalign;
    w_target       = taken_target(alu_result);

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_inst_nxt  = imem_rdata;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HOLD: begin
        // selPC/alu_result matter only in the commit cycle
        if (commit) begin
          if (selPC == PC_TAKEN) begin
            w_pc_nxt = w_target;
            if (w_target[1]) begin
              // Half-word aligned target: park the pc there and stop
              w_misalign_nxt = 1'b1;
              w_state_nxt    = ST_HALT;
            end else begin
              w_state_nxt = ST_FETCH;
            end
          end else begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_imem_req_nxt   = (w_state_nxt == ST_FETCH);
    w_inst_valid_nxt = (w_state_nxt == ST_HOLD);
    if (w_inst_valid_nxt) begin
      w_inst_out_nxt = w_inst_nxt;
    end else begin
      w_inst_out_nxt = NOP_INST;
    end
    w_pc_four_nxt = w_pc_nxt + 32'd4;
  end

  // State, pc, instruction register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_misalign   <= 1'b0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= NOP_INST;
      r_pc_four    <= RESET_PC + 32'd4;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_misalign   <= w_misalign_nxt;
      r_imem_req   <= w_imem_req_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst_out   <= w_inst_out_nxt;
      r_pc_four    <= w_pc_four_nxt;
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign pc_four    = r_pc_four;
  assign inst       = r_inst_out;
  assign inst_valid = r_inst_valid;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed self-checking bench for inst_fetch. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled at that same point, after the
// registered outputs have settled.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        selPC;
  logic [31:0] alu_result;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic [31:0] inst;
  logic        inst_valid;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .selPC     (selPC),
    .alu_result(alu_result),
    .commit    (commit),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pc        (pc),
    .pc_four   (pc_four),
    .inst      (inst),
    .inst_valid(inst_valid),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    selPC      = 1'b0;
    alu_result = 32'h0;
    commit     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
    n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc); end
    n_checks++; if (pc_four !== 32'h4) begin n_fail++; $display("FAIL reset_pc_four got=%h exp=4", pc_four); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%0b exp=0", misalign); end
  endtask

  // ack every cycle, commit always high: FETCH/HOLD alternate at 0,4,8
  task automatic test_sequential();
    logic        exp_req;
    logic [31:0] exp_addr;
    do_reset();
    imem_ack = 1'b1;
    commit   = 1'b1;
    selPC    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      imem_rdata = 32'h1000_0000 + k;
      alu_result = 32'hDEAD_0000 + k;  // must be ignored, selPC=0
      step();
      exp_req  = ((k % 2) == 0);
      exp_addr = (k / 2) * 4;
      n_checks++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL seq_req k=%0d got=%0b exp=%0b", k, imem_req, exp_req); end
      n_checks++; if (inst_valid !== !exp_req) begin n_fail++; $display("FAIL seq_valid k=%0d got=%0b exp=%0b", k, inst_valid, !exp_req); end
      n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, imem_addr, exp_addr); end
      n_checks++; if (pc_four !== exp_addr + 32'd4) begin n_fail++; $display("FAIL seq_pc_four k=%0d got=%h exp=%h", k, pc_four, exp_addr + 32'd4); end
      if (!exp_req) begin
        n_checks++; if (inst !== 32'h1000_0000 + k) begin n_fail++; $display("FAIL seq_inst k=%0d got=%h exp=%h", k, inst, 32'h1000_0000 + k); end
      end else begin
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL seq_nop k=%0d got=%h exp=%h", k, inst, NOP); end
      end
    end
  endtask

  // three cycles without ack, then ack with 0x00500093
  task automatic test_wait_states();
    do_reset();
    step();  // IDLE -> FETCH
    for (int k = 0; k < 3; k++) begin
      imem_rdata = 32'hBAD0_0000 + k;  // not acked, must not be latched
      step();
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req k=%0d got=%0b exp=1", k, imem_req); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid k=%0d got=%0b exp=0", k, inst_valid); end
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wait_pc k=%0d got=%h exp=0", k, pc); end
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_ack   = 1'b0;
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL wait_ack_valid got=%0b exp=1", inst_valid); end
    n_checks++; if (inst !== 32'h0050_0093) begin n_fail++; $display("FAIL wait_ack_inst got=%h exp=00500093", inst); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wait_ack_pc got=%h exp=0", pc); end
  endtask

  // continues from HOLD with 0x00500093 at pc 0; commit low for 5 cycles
  task automatic test_hold_stable();
    commit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      selPC      = 1'b1;
      alu_result = 32'h0000_0100 + k;
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_0000 + k;
      step();
      n_checks++; if (inst !== 32'h0050_0093) begin n_fail++; $display("FAIL hold_inst k=%0d got=%h exp=00500093", k, inst); end
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL hold_pc k=%0d got=%h exp=0", k, pc); end
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid k=%0d got=%0b exp=1", k, inst_valid); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req k=%0d got=%0b exp=0", k, imem_req); end
    end
    imem_ack = 1'b0;
  endtask

  // walk to HOLD at 0x10, branch to 0x41 -> fetch 0x40, then misaligned 0x42
  task automatic test_branch_and_misalign();
    do_reset();
    imem_ack = 1'b1;
    commit   = 1'b1;
    selPC    = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_checks++; if (pc !== 32'h10 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL br_setup got pc=%h valid=%0b exp pc=10 valid=1", pc, inst_valid); end
    selPC      = 1'b1;
    alu_result = 32'h0000_0041;
    imem_ack   = 1'b0;
    step();
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_addr got=%h exp=40", imem_addr); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL br_req got=%0b exp=1", imem_req); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL br_misalign got=%0b exp=0", misalign); end
    n_checks++; if (pc_four !== 32'h44) begin n_fail++; $display("FAIL br_pc_four got=%h exp=44", pc_four); end
    imem_ack = 1'b1;
    step();  // HOLD at 0x40
    alu_result = 32'h0000_0042;
    step();
    n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag got=%0b exp=1", misalign); end
    n_checks++; if (pc !== 32'h42) begin n_fail++; $display("FAIL mis_pc got=%h exp=42", pc); end
    for (int k = 0; k < 3; k++) begin
      alu_result = 32'h0000_0080;
      step();
      n_checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_out k=%0d got req=%0b valid=%0b exp 0 0", k, imem_req, inst_valid); end
      n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL halt_inst k=%0d got=%h exp=%h", k, inst, NOP); end
      n_checks++; if (pc !== 32'h42 || misalign !== 1'b1) begin n_fail++; $display("FAIL halt_hold k=%0d got pc=%h mis=%0b exp 42 1", k, pc, misalign); end
    end
    do_reset();
    n_checks++; if (pc !== 32'h0 || misalign !== 1'b0) begin n_fail++; $display("FAIL halt_rst got pc=%h mis=%0b exp 0 0", pc, misalign); end
  endtask

  // rst together with imem_ack mid-FETCH: nothing latched, refetch from 0
  task automatic test_reset_mid_fetch();
    do_reset();
    step();  // FETCH
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_fail++; $display("FAIL rstf_inst got valid=%0b inst=%h exp 0 %h", inst_valid, inst, NOP); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rstf_req got=%0b exp=0", imem_req); end
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rstf_refetch got req=%0b addr=%h exp 1 0", imem_req, imem_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstf_valid got=%0b exp=0", inst_valid); end
  endtask

  // taken jump to 0xFFFFFFFC, then sequential step wraps to 0
  task automatic test_wrap();
    do_reset();
    imem_ack = 1'b1;
    step();  // FETCH
    step();  // HOLD
    commit     = 1'b1;
    selPC      = 1'b1;
    alu_result = 32'hFFFF_FFFD;
    step();
    n_checks++; if (pc !== 32'hFFFF_FFFC || pc_four !== 32'h0) begin n_fail++; $display("FAIL wrap_jump got pc=%h pc4=%h exp fffffffc 0", pc, pc_four); end
    selPC = 1'b0;
    step();  // HOLD at 0xFFFFFFFC
    step();
    n_checks++; if (pc !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_seq got pc=%h req=%0b exp 0 1", pc, imem_req); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL wrap_flag got=%0b exp=0", misalign); end
    commit   = 1'b0;
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_hold_stable();
    test_branch_and_misalign();
    test_reset_mid_fetch();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
